ingr_err_drop_fifo: RTL and testbench

Store-and-forward ingress packet filter placed directly upstream of the ingress tuser-removal stage. Buffers each packet in full and forwards it only once its last beat has been seen with no error. A packet is discarded when the one-bit `tuser` error flag was asserted on any of its beats, or when the packet overflows the buffer. The downstream stage then strips `tuser`, which this block always drives low.

---
 rtl/ingr_err_drop_fifo_if.sv | 32 +++
 rtl/ingr_err_drop_fifo.sv | 142 ++++++++++++++
 tb/tb_ingr_err_drop_fifo.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ingr_err_drop_fifo_if.sv
`default_nettype none
// ============================================================================
// ingr_err_drop_fifo_if : AXI-Stream bundle (data, tuser, tid, tdest, tkeep, tlast)
// Rev 1.0
// ============================================================================
interface ingr_err_drop_fifo_if #(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 4
) ();
  localparam int TID_W  = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1;
  localparam int KEEP_W = AXIS_BUS_WIDTH / 8;

  logic [AXIS_BUS_WIDTH-1:0] tdata;
  logic                      tuser;
  logic [TID_W-1:0]          tid;
  logic [AXIS_ID_WIDTH:0]    tdest;
  logic [KEEP_W-1:0]         tkeep;
  logic                      tlast;
  logic                      tvalid;
  logic                      tready;

  modport master (
    output tdata, tuser, tid, tdest, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tuser, tid, tdest, tkeep, tlast, tvalid,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/ingr_err_drop_fifo.sv
`default_nettype none
// ============================================================================
// ingr_err_drop_fifo : store-and-forward filter dropping errored or overflowing packets
// Rev 1.0
// ============================================================================
module ingr_err_drop_fifo #(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 4,
  parameter int FIFO_DEPTH     = 64
) (
  input  wire logic            aclk,
  input  wire logic            areset,
  ingr_err_drop_fifo_if.slave  axis_in,
  ingr_err_drop_fifo_if.master axis_out,
  output logic [15:0]          stat_err_drops,
  output logic [15:0]          stat_ovf_drops
);

  localparam int TID_W   = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1;
  localparam int KEEP_W  = AXIS_BUS_WIDTH / 8;
  localparam int ENTRY_W = AXIS_BUS_WIDTH + TID_W + AXIS_ID_WIDTH + 1 + KEEP_W + 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   wr_commit_q, wr_commit_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          err_q, err_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [15:0]   ovf_cnt_q, ovf_cnt_d;

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

  logic               full;
  logic               committed_empty;
  logic               in_ready;
  logic               wr_en;
  logic               rd_fire;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign full            = ((wr_ptr_q - rd_ptr_q) == C_DEPTH);
  assign committed_empty = (rd_ptr_q == wr_commit_q);
  assign rd_fire         = !committed_empty && axis_out.tready;

  assign wr_entry = {axis_in.tlast, axis_in.tkeep, axis_in.tdest, axis_in.tid, axis_in.tdata};
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    rd_ptr_d    = rd_ptr_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    ovf_cnt_d   = ovf_cnt_q;
    in_ready    = 1'b1;
    wr_en       = 1'b0;

    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case (state_q)
      ST_PASS: begin
        in_ready = !full;
        // A buffer filled by one packet with nothing committed can never drain.
        if (full && committed_empty) begin
          state_d = ST_DROP;
        end else if (axis_in.tvalid && !full) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (axis_in.tlast) begin
            err_d = 1'b0;
            if (err_q || axis_in.tuser) begin
              wr_ptr_d  = wr_commit_q;
              err_cnt_d = err_cnt_q + 16'd1;
            end else begin
              wr_commit_d = wr_ptr_q + 1'b1;
            end
          end else begin
            err_d = err_q | axis_in.tuser;
          end
        end
      end
      ST_DROP: begin
        in_ready = 1'b1;
        if (axis_in.tvalid && axis_in.tlast) begin
          wr_ptr_d  = wr_commit_q;
          err_d     = 1'b0;
          ovf_cnt_d = ovf_cnt_q + 16'd1;
          state_d   = ST_PASS;
        end
      end
      default: begin
        state_d = ST_PASS;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_PASS;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end

  assign axis_in.tready  = in_ready;
  assign axis_out.tvalid = !committed_empty;
  assign axis_out.tuser  = 1'b0;
  assign {axis_out.tlast, axis_out.tkeep, axis_out.tdest, axis_out.tid, axis_out.tdata} = rd_entry;

  assign stat_err_drops = err_cnt_q;
  assign stat_ovf_drops = ovf_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ingr_err_drop_fifo.sv
`default_nettype none
// ============================================================================
// tb_ingr_err_drop_fifo : randomized bench with queue-based packet model
// Rev 1.0
// ============================================================================
module tb_ingr_err_drop_fifo;
  localparam int DW    = 64;
  localparam int IDW   = 4;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [IDW-1:0]  id;
    logic [IDW:0]    dest;
    logic [DW/8-1:0] keep;
    logic            last;
  } beat_t;

  logic        clk;
  logic        areset;
  logic [15:0] stat_err_drops;
  logic [15:0] stat_ovf_drops;

  ingr_err_drop_fifo_if #(.AXIS_BUS_WIDTH(DW), .AXIS_ID_WIDTH(IDW)) in_if ();
  ingr_err_drop_fifo_if #(.AXIS_BUS_WIDTH(DW), .AXIS_ID_WIDTH(IDW)) out_if ();

  ingr_err_drop_fifo #(
    .AXIS_BUS_WIDTH(DW),
    .AXIS_ID_WIDTH (IDW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .aclk          (clk),
    .areset        (areset),
    .axis_in       (in_if),
    .axis_out      (out_if),
    .stat_err_drops(stat_err_drops),
    .stat_ovf_drops(stat_ovf_drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: committed beats awaiting output, beats of the packet being received.
  beat_t exp_q[$];
  beat_t pkt_q[$];
  bit    m_drop = 0;
  bit    m_err  = 0;
  int    m_errcnt = 0;
  int    m_ovfcnt = 0;
  int    out_beats = 0;
  int    in_acc = 0;
  int    occ;
  bit    exp_ready, out_fire, in_fire, was_empty;
  beat_t in_b;

  always @(negedge clk) begin
    if (areset) begin
      exp_q.delete();
      pkt_q.delete();
      m_drop = 0;
      m_err  = 0;
      m_errcnt = 0;
      m_ovfcnt = 0;
    end else begin
      occ       = exp_q.size() + pkt_q.size();
      exp_ready = m_drop || (occ != DEPTH);
      was_empty = (exp_q.size() == 0);
      chk("out_tvalid", 64'(out_if.tvalid), 64'(!was_empty));
      if (!was_empty) begin
        chk("out_tdata", out_if.tdata, exp_q[0].data);
        chk("out_tid",   64'(out_if.tid),   64'(exp_q[0].id));
        chk("out_tdest", 64'(out_if.tdest), 64'(exp_q[0].dest));
        chk("out_tkeep", 64'(out_if.tkeep), 64'(exp_q[0].keep));
        chk("out_tlast", 64'(out_if.tlast), 64'(exp_q[0].last));
      end
      chk("out_tuser", 64'(out_if.tuser), 64'd0);
      chk("in_tready", 64'(in_if.tready), 64'(exp_ready));
      chk("stat_err_drops", 64'(stat_err_drops), 64'(16'(m_errcnt)));
      chk("stat_ovf_drops", 64'(stat_ovf_drops), 64'(16'(m_ovfcnt)));

      out_fire = !was_empty && out_if.tready;
      in_fire  = in_if.tvalid && exp_ready;
      if (out_fire) begin
        void'(exp_q.pop_front());
        out_beats++;
      end
      if (in_fire) in_acc++;
      if (m_drop) begin
        if (in_fire && in_if.tlast) begin
          m_drop = 0;
          m_err  = 0;
          m_ovfcnt++;
          pkt_q.delete();
        end
      end else if (occ == DEPTH) begin
        if (was_empty) m_drop = 1;
      end else if (in_fire) begin
        in_b = '{data: in_if.tdata, id: in_if.tid, dest: in_if.tdest,
                 keep: in_if.tkeep, last: in_if.tlast};
        pkt_q.push_back(in_b);
        if (in_if.tlast) begin
          if (m_err || in_if.tuser) m_errcnt++;
          else foreach (pkt_q[k]) exp_q.push_back(pkt_q[k]);
          pkt_q.delete();
          m_err = 0;
        end else begin
          m_err = m_err | in_if.tuser;
        end
      end
    end
  end

  // Output ready: 0 = always ready, 1 = stalled, 2 = random.
  int out_mode = 0;
  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        0:       out_if.tready = 1'b1;
        1:       out_if.tready = 1'b0;
        default: out_if.tready = 1'($urandom % 2);
      endcase
    end
  end

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  task automatic send_beat(input logic last, input logic user);
    bit ok = 0;
    in_if.tdata  = {$urandom, $urandom};
    in_if.tid    = IDW'($urandom);
    in_if.tdest  = (IDW+1)'($urandom);
    in_if.tkeep  = (DW/8)'($urandom);
    in_if.tlast  = last;
    in_if.tuser  = user;
    in_if.tvalid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      ok = in_if.tready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_if.tvalid = 1'b0;
    if (!ok) begin
      chk("send_timeout", 64'd1, 64'd0);
      finish_run();
    end
  endtask

  task automatic send_pkt(input int len, input int err_beat, input int err_pct, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        while ($urandom % 4 == 0) begin
          @(posedge clk);
          #1;
        end
      end
      send_beat(i == len - 1, (i == err_beat) || (($urandom % 100) < err_pct));
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_if.tvalid) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  int base_in, base_out;

  initial begin
    areset       = 1'b1;
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tid    = '0;
    in_if.tdest  = '0;
    in_if.tkeep  = '0;
    in_if.tlast  = 1'b0;
    in_if.tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    areset = 1'b0;
    chk("ready_after_reset", 64'(in_if.tready), 64'd1);

    // Good 3-beat packet
    base_out = out_beats;
    send_pkt(3, -1, 0, 0);
    wait_drain();
    chk("good_out_beats", 64'(out_beats - base_out), 64'd3);
    chk("good_err_cnt", 64'(stat_err_drops), 64'd0);

    // Error on beat 2 of 4, then good 2-beat
    base_out = out_beats;
    send_pkt(4, 1, 0, 0);
    send_pkt(2, -1, 0, 0);
    wait_drain();
    chk("errdrop_out_beats", 64'(out_beats - base_out), 64'd2);
    chk("errdrop_cnt", 64'(stat_err_drops), 64'd1);

    // Overflow: 20-beat packet into 16-deep buffer, output stalled
    out_mode = 1;
    base_out = out_beats;
    send_pkt(20, -1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_cnt", 64'(stat_ovf_drops), 64'd1);
    chk("ovf_no_output", 64'(out_if.tvalid), 64'd0);
    out_mode = 0;
    send_pkt(4, -1, 0, 0);
    wait_drain();
    chk("after_ovf_out_beats", 64'(out_beats - base_out), 64'd4);

    // 12 committed beats, then an 8-beat packet stalls at 4 beats in
    out_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    base_in  = in_acc;
    base_out = out_beats;
    send_pkt(4, -1, 0, 0);
    send_pkt(4, -1, 0, 0);
    send_pkt(4, -1, 0, 0);
    fork
      send_pkt(8, -1, 0, 0);
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("stall_accepted", 64'(in_acc - base_in), 64'd16);
        chk("stall_ready_low", 64'(in_if.tready), 64'd0);
        out_mode = 0;
      end
    join
    wait_drain();
    chk("full_out_beats", 64'(out_beats - base_out), 64'd20);
    chk("full_no_ovf", 64'(stat_ovf_drops), 64'd1);

    // Asynchronous reset mid-packet with output stalled
    out_mode = 1;
    send_pkt(3, -1, 0, 0);
    send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b1);
    in_if.tvalid = 1'b1;
    in_if.tlast  = 1'b0;
    #3;
    areset = 1'b1;
    #1;
    chk("rst_tvalid", 64'(out_if.tvalid), 64'd0);
    chk("rst_err_cnt", 64'(stat_err_drops), 64'd0);
    chk("rst_ovf_cnt", 64'(stat_ovf_drops), 64'd0);
    in_if.tvalid = 1'b0;
    @(posedge clk);
    #1;
    areset   = 1'b0;
    out_mode = 0;
    base_out = out_beats;
    send_pkt(5, -1, 0, 0);
    wait_drain();
    chk("post_rst_out_beats", 64'(out_beats - base_out), 64'd5);

    // Randomized soak
    out_mode = 2;
    for (int p = 0; p < 60; p++) begin
      if ($urandom % 8 == 0) send_pkt(17 + int'($urandom % 4), -1, 8, 1);
      else                   send_pkt(1 + int'($urandom % 10), -1, 8, 1);
    end
    out_mode = 0;
    wait_drain();
    chk("soak_err_cnt", 64'(stat_err_drops), 64'(16'(m_errcnt)));
    chk("soak_ovf_cnt", 64'(stat_ovf_drops), 64'(16'(m_ovfcnt)));

    finish_run();
  end

  initial begin
    #2000000;
    chk("global_timeout", 64'd1, 64'd0);
    finish_run();
  end

endmodule
`default_nettype wire
